// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder and its nibble slice.
// The state encoding and index-width helper are used by the top-level sequencer.
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned NIB_W = 4;

    // Bits needed to count nib values; never less than one.
    function automatic int unsigned idx_width(input int unsigned nib);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < nib) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/cla_adder_4.sv
// Four-bit carry-lookahead adder slice: all internal carries come from
// generate/propagate terms rather than a ripple chain.
module cla_adder_4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g = A & B;
        p = A ^ B;

        c[0] = Cin;
        c[1] = g[0] | (p[0] & Cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & Cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & Cin);

        S    = p ^ c[3:0];
        Cout = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that feeds one 4-bit CLA slice a nibble per clock, LSB first,
// carrying between nibbles in a register. Start/busy/done handshake.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned IDX_W = idx_width(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    if (((WIDTH % NIB_W) != 0) || (WIDTH < NIB_W)) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [NIB_W-1:0] nib_s;
    logic             nib_cout;
    logic             last_nib;

    cla_adder_4 u_nib (
        .A    (a_sh_q[NIB_W-1:0]),
        .B    (b_sh_q[NIB_W-1:0]),
        .Cin  (carry_q),
        .S    (nib_s),
        .Cout (nib_cout)
    );

    assign last_nib = (idx_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    idx_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_sh_d  = a_sh_q >> NIB_W;
                b_sh_d  = b_sh_q >> NIB_W;
                // New nibble enters at the top; after NIB steps the LSB nibble sits at bit 0.
                sum_d   = WIDTH'({nib_s, sum_q} >> NIB_W);
                carry_d = nib_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (last_nib) begin
                    state_d = StDone;
                    cout_d  = nib_cout;
                    ovf_d   = (a_msb_q == b_msb_q) && (nib_s[NIB_W-1] != a_msb_q);
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_q == StRun) && last_nib;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder at WIDTH 4, 16 and 32: directed vectors, multi-cycle
// handshake corner cases and random operations against an arithmetic reference.
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        st4, cin4, busy4, done4, cout4, ovf4;
    logic [3:0]  a4, b4, sum4;
    logic        st16, cin16, busy16, done16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;
    logic        st32, cin32, busy32, done32, cout32, ovf32;
    logic [31:0] a32, b32, sum32;

    nibble_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
    );
    nibble_serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .a(a16), .b(b16), .cin(cin16),
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16)
    );
    nibble_serial_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(st32), .a(a32), .b(b32), .cin(cin32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .overflow(ovf32)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Reference: plain integer sum, and overflow from the signed value falling out of range.
    task automatic model(input int w, input logic [63:0] a, input logic [63:0] b,
                         input logic c, output logic [63:0] s, output logic co,
                         output logic ov);
        logic [63:0] t;
        longint      sa, sb, ss, lim;
        t   = a + b + 64'(c);
        s   = t & mask(w);
        co  = t[w];
        lim = longint'(1) << (w - 1);
        sa  = a[w-1] ? longint'(a) - (lim << 1) : longint'(a);
        sb  = b[w-1] ? longint'(b) - (lim << 1) : longint'(b);
        ss  = sa + sb + longint'(c);
        ov  = (ss >= lim) || (ss < -lim);
    endtask

    task automatic drive(input int w, input logic st, input logic [63:0] a,
                         input logic [63:0] b, input logic c);
        case (w)
            4:  begin st4  = st; a4  = a[3:0];  b4  = b[3:0];  cin4  = c; end
            16: begin st16 = st; a16 = a[15:0]; b16 = b[15:0]; cin16 = c; end
            32: begin st32 = st; a32 = a[31:0]; b32 = b[31:0]; cin32 = c; end
            default: ;
        endcase
    endtask

    function automatic logic o_busy(input int w);
        case (w)
            4:       return busy4;
            16:      return busy16;
            default: return busy32;
        endcase
    endfunction

    function automatic logic o_done(input int w);
        case (w)
            4:       return done4;
            16:      return done16;
            default: return done32;
        endcase
    endfunction

    function automatic logic o_cout(input int w);
        case (w)
            4:       return cout4;
            16:      return cout16;
            default: return cout32;
        endcase
    endfunction

    function automatic logic o_ovf(input int w);
        case (w)
            4:       return ovf4;
            16:      return ovf16;
            default: return ovf32;
        endcase
    endfunction

    function automatic logic [63:0] o_sum(input int w);
        case (w)
            4:       return 64'(sum4);
            16:      return 64'(sum16);
            default: return 64'(sum32);
        endcase
    endfunction

    // Called at a negedge (cycle 0); returns at the negedge of the done cycle.
    task automatic run_op(input int w, input logic [63:0] a, input logic [63:0] b,
                          input logic c, input logic [63:0] es, input logic eco,
                          input logic eov, input string tag);
        int nib;
        int cyc;
        logic busy_ok;
        nib = w / 4;
        drive(w, 1'b1, a, b, c);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, a, b, c);
        cyc     = 1;
        busy_ok = 1'b1;
        while (o_done(w) !== 1'b1 && cyc <= nib + 5) begin
            if (o_busy(w) !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({tag, " done_cycle"}, 64'(cyc), 64'(nib + 1));
        check({tag, " busy_in_run"}, 64'(busy_ok), 64'd1);
        check({tag, " busy_at_done"}, 64'(o_busy(w)), 64'd0);
        check({tag, " sum"}, o_sum(w), es);
        check({tag, " cout"}, 64'(o_cout(w)), 64'(eco));
        check({tag, " overflow"}, 64'(o_ovf(w)), 64'(eov));
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t vecs[5];

    initial begin
        logic [63:0] ra, rb, es;
        logic        rc, eco, eov, done_seen;
        int          widths[3];

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        widths  = '{4, 16, 32};

        rst_n = 1'b0;
        drive(4, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(16, 1'b0, 64'd0, 64'd0, 1'b0);
        drive(32, 1'b0, 64'd0, 64'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy16), 64'd0);
        check("reset done", 64'(done16), 64'd0);
        check("reset sum", 64'(sum16), 64'd0);
        check("reset cout", 64'(cout16), 64'd0);
        check("reset overflow", 64'(ovf16), 64'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            run_op(16, 64'(vecs[i].a), 64'(vecs[i].b), vecs[i].cin, 64'(vecs[i].sum),
                   vecs[i].cout, vecs[i].ovf, $sformatf("vec%0d", i));
        end
        step();

        // Start pulsed with new operands mid-run must not disturb the operation.
        drive(16, 1'b1, 64'h1234, 64'h4321, 1'b1);
        step();
        drive(16, 1'b0, 64'h1234, 64'h4321, 1'b1);
        step();
        drive(16, 1'b1, 64'hFFFF, 64'hFFFF, 1'b0);
        step();
        step();
        drive(16, 1'b0, 64'hFFFF, 64'hFFFF, 1'b0);
        check("midstart busy c4", 64'(busy16), 64'd1);
        step();
        check("midstart done c5", 64'(done16), 64'd1);
        check("midstart sum", 64'(sum16), 64'h5556);
        check("midstart cout", 64'(cout16), 64'd0);
        step();
        check("midstart done once", 64'(done16), 64'd0);

        // Back-to-back: start held through DONE; operands swapped while running.
        drive(16, 1'b1, 64'h1111, 64'h2222, 1'b0);
        step();
        drive(16, 1'b1, 64'h00FF, 64'h0F01, 1'b0);
        repeat (4) step();
        check("b2b done1", 64'(done16), 64'd1);
        check("b2b sum1", 64'(sum16), 64'h3333);
        step();
        drive(16, 1'b0, 64'h00FF, 64'h0F01, 1'b0);
        check("b2b busy c6", 64'(busy16), 64'd1);
        check("b2b done c6", 64'(done16), 64'd0);
        check("b2b sum held", 64'(sum16), 64'h3333);
        repeat (4) step();
        check("b2b done2", 64'(done16), 64'd1);
        check("b2b sum2", 64'(sum16), 64'h1000);
        check("b2b cout2", 64'(cout16), 64'd0);
        check("b2b ovf2", 64'(ovf16), 64'd0);
        step();

        // Reset in cycle 3 of a run discards it; no done follows.
        run_op(16, 64'h8000, 64'h8000, 1'b0, 64'h0000, 1'b1, 1'b1, "pre_rst");
        drive(16, 1'b1, 64'hAAAA, 64'h5555, 1'b0);
        step();
        drive(16, 1'b0, 64'hAAAA, 64'h5555, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        step();
        check("rst busy", 64'(busy16), 64'd0);
        check("rst done", 64'(done16), 64'd0);
        check("rst sum", 64'(sum16), 64'd0);
        check("rst cout", 64'(cout16), 64'd0);
        check("rst overflow", 64'(ovf16), 64'd0);
        rst_n = 1'b1;
        done_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done16 === 1'b1 || busy16 === 1'b1) done_seen = 1'b1;
            step();
        end
        check("rst no done", 64'(done_seen), 64'd0);
        run_op(16, 64'h0F0F, 64'h0101, 1'b1, 64'h1011, 1'b0, 1'b0, "post_rst");

        foreach (widths[k]) begin
            for (int i = 0; i < 1000; i++) begin
                ra = {32'($urandom), 32'($urandom)} & mask(widths[k]);
                rb = {32'($urandom), 32'($urandom)} & mask(widths[k]);
                rc = 1'($urandom);
                if (i % 10 == 0) ra = mask(widths[k]);
                model(widths[k], ra, rb, rc, es, eco, eov);
                run_op(widths[k], ra, rb, rc, es, eco, eov,
                       $sformatf("rand w%0d #%0d", widths[k], i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
